// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, state/op-class encodings and select codes for the multicycle controller
package ctrl_pkg;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {OP_R, OP_IMM, OP_LW, OP_SW, OP_LUI, OP_BR, OP_JAL, OP_ILL} op_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funct classifier; branch/JAL decoded only with CTRL_BRANCH_EN
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output op_t         op,
    output logic [3:0]  alu_sel,
    output logic [2:0]  imm_sel
);
    logic [2:0] f3;
    logic       unused_bits;

    assign f3          = instr[14:12];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // classify opcode; anything not listed falls through to OP_ILL
    always_comb begin
        op      = OP_ILL;
        alu_sel = ALU_ADD;
        imm_sel = IMM_I;
        case (instr[6:0])
            OPC_R: begin
                op      = OP_R;
                alu_sel = {instr[30], f3};
            end
            OPC_IMM: begin
                op      = OP_IMM;
                alu_sel = {(f3 == 3'b101) & instr[30], f3};
            end
            OPC_LOAD:  op = OP_LW;
            OPC_STORE: begin
                op      = OP_SW;
                imm_sel = IMM_S;
            end
            OPC_LUI: begin
                op      = OP_LUI;
                imm_sel = IMM_U;
            end
`ifdef CTRL_BRANCH_EN
            OPC_BRANCH: begin
                op      = OP_BR;
                imm_sel = IMM_B;
            end
            OPC_JAL: begin
                op      = OP_JAL;
                imm_sel = IMM_J;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout; CTRL_BRANCH_EN adds beq/bne/JAL
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int IMMSEL_W = 3,
    parameter int ALUSEL_W = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                br_eq,
    output logic                ir_wen,
    output logic                pc_wen,
    output logic                pc_sel,
    output logic [IMMSEL_W-1:0] imm_sel,
    output logic                a_sel,
    output logic                b_sel,
    output logic [ALUSEL_W-1:0] alu_sel,
    output logic                reg_wen,
    output logic [1:0]          wb_sel,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic [1:0]          fault
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        state, state_n;
    op_t           op;
    logic [3:0]    dec_alu;
    logic [2:0]    dec_imm;
    logic [CW-1:0] cnt;
    logic [1:0]    fault_n;
    logic          last;
    logic          taken;
    logic          is_mem;

    ctrl_decode u_decode (
        .instr  (instr),
        .op     (op),
        .alu_sel(dec_alu),
        .imm_sel(dec_imm)
    );

`ifdef CTRL_BRANCH_EN
    assign taken = (instr[14:12] == 3'b000) ? br_eq : !br_eq;
`else
    logic unused_br;
    assign unused_br = br_eq;
    assign taken     = 1'b0;
`endif

    assign last   = cnt == CW'(TIMEOUT - 1);
    assign is_mem = (op == OP_LW) || (op == OP_SW);

    // state, sticky fault and wait counter; counter restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            fault <= FAULT_NONE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            fault <= fault_n;
            cnt   <= (state_n != state) ? '0 : (mem_req && !mem_ready) ? cnt + CW'(1) : cnt;
        end
    end

    // next state and Moore-style datapath controls; strobes masked while rst is held
    always_comb begin
        state_n      = state;
        fault_n      = fault;
        ir_wen       = 1'b0;
        pc_wen       = 1'b0;
        pc_sel       = 1'b0;
        imm_sel      = '0;
        a_sel        = 1'b0;
        b_sel        = 1'b0;
        alu_sel      = '0;
        reg_wen      = 1'b0;
        wb_sel       = WB_MEM;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = !rst;
                ir_wen  = !rst && mem_ready;
                state_n = mem_ready ? S_DECODE : last ? S_TRAP : S_FETCH;
                fault_n = (!mem_ready && last) ? FAULT_TIMEOUT : fault;
            end
            S_DECODE: begin
                state_n = (op == OP_ILL) ? S_TRAP : S_EXEC;
                fault_n = (op == OP_ILL) ? FAULT_ILLEGAL : fault;
            end
            S_EXEC: begin
                imm_sel = IMMSEL_W'(dec_imm);
                alu_sel = ALUSEL_W'(dec_alu);
                a_sel   = (op == OP_LUI) || (op == OP_BR) || (op == OP_JAL);
                b_sel   = op != OP_R;
                pc_wen  = op == OP_BR;
                pc_sel  = (op == OP_BR) && taken;
                state_n = is_mem ? S_MEM : (op == OP_BR) ? S_FETCH : S_WB;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = op == OP_SW;
                pc_wen       = mem_ready && (op == OP_SW);
                state_n      = mem_ready ? ((op == OP_SW) ? S_FETCH : S_WB) : last ? S_TRAP : S_MEM;
                fault_n      = (!mem_ready && last) ? FAULT_TIMEOUT : fault;
            end
            S_WB: begin
                reg_wen = 1'b1;
                pc_wen  = 1'b1;
                pc_sel  = op == OP_JAL;
                wb_sel  = (op == OP_LW) ? WB_MEM : (op == OP_JAL) ? WB_PC4 : WB_ALU;
                state_n = S_FETCH;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random and directed instruction traces checked cycle by cycle against a trace model
module tb_multicycle_controller;
    localparam int TO = 6;
    localparam logic [6:0] O_R = 7'h33, O_IMM = 7'h13, O_LD = 7'h03, O_ST = 7'h23;
    localparam logic [6:0] O_LUI = 7'h37, O_BR = 7'h63, O_JAL = 7'h6F;

    typedef struct packed {
        logic       ir_wen;
        logic       pc_wen;
        logic       pc_sel;
        logic [2:0] imm_sel;
        logic       a_sel;
        logic       b_sel;
        logic [3:0] alu_sel;
        logic       reg_wen;
        logic [1:0] wb_sel;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic [1:0] fault;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        br_eq = 1'b0;
    logic        ir_wen, pc_wen, pc_sel, a_sel, b_sel, reg_wen, mem_req, mem_we, mem_addr_sel;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_sel;
    logic [1:0]  wb_sel, fault;
    outs_t       obs;

    int n_checks = 0;
    int n_fail = 0;
    outs_t exp_q[$];
    logic  rdy_q[$];

    always #5 clk = ~clk;

    multicycle_controller #(.IMMSEL_W(3), .ALUSEL_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_eq(br_eq),
        .ir_wen(ir_wen), .pc_wen(pc_wen), .pc_sel(pc_sel), .imm_sel(imm_sel),
        .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel), .reg_wen(reg_wen),
        .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .fault(fault)
    );

    assign obs = {ir_wen, pc_wen, pc_sel, imm_sel, a_sel, b_sel, alu_sel, reg_wen,
                  wb_sel, mem_req, mem_we, mem_addr_sel, fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    task automatic push(input outs_t o, input logic r);
        exp_q.push_back(o);
        rdy_q.push_back(r);
    endtask

    task automatic add_trap(input logic [1:0] code);
        outs_t o;
        o = '0;
        o.fault = code;
        for (int i = 0; i < 3; i++) push(o, rb());
    endtask

    // expected per-cycle outputs of one instruction given fetch/data wait lengths
    task automatic gen(input logic [31:0] ins, input int df, input int dm, input logic beq, output bit trapped);
        outs_t o;
        logic [6:0] opc;
        logic [2:0] f3;
        bit r, im, lw, sw, lui, br, jal;
        opc = ins[6:0];
        f3  = ins[14:12];
        r   = opc == O_R;
        im  = opc == O_IMM;
        lw  = opc == O_LD;
        sw  = opc == O_ST;
        lui = opc == O_LUI;
`ifdef CTRL_BRANCH_EN
        br  = opc == O_BR;
        jal = opc == O_JAL;
`else
        br  = 1'b0;
        jal = 1'b0;
`endif
        trapped = 1'b1;
        o = '0;
        o.mem_req = 1'b1;
        for (int i = 0; i < df && i < TO; i++) push(o, 1'b0);
        if (df >= TO) begin
            add_trap(2'd2);
            return;
        end
        o.ir_wen = 1'b1;
        push(o, 1'b1);
        push('0, rb());
        if (!(r || im || lw || sw || lui || br || jal)) begin
            add_trap(2'd1);
            return;
        end
        o = '0;
        o.imm_sel = sw ? 3'd1 : br ? 3'd2 : lui ? 3'd3 : jal ? 3'd4 : 3'd0;
        o.a_sel   = lui || br || jal;
        o.b_sel   = !r;
        o.alu_sel = r ? {ins[30], f3} : (im && f3 == 3'd5) ? {ins[30], f3} : im ? {1'b0, f3} : 4'd0;
        trapped = 1'b0;
        if (br) begin
            o.pc_wen = 1'b1;
            o.pc_sel = (f3 == 3'd0) ? beq : !beq;
            push(o, rb());
            return;
        end
        push(o, rb());
        if (lw || sw) begin
            o = '0;
            o.mem_req = 1'b1;
            o.mem_addr_sel = 1'b1;
            o.mem_we = sw;
            for (int i = 0; i < dm && i < TO; i++) push(o, 1'b0);
            if (dm >= TO) begin
                add_trap(2'd2);
                trapped = 1'b1;
                return;
            end
            o.pc_wen = sw;
            push(o, 1'b1);
            if (sw) return;
        end
        o = '0;
        o.reg_wen = 1'b1;
        o.pc_wen  = 1'b1;
        o.pc_sel  = jal;
        o.wb_sel  = lw ? 2'd0 : jal ? 2'd2 : 2'd1;
        push(o, rb());
    endtask

    task automatic play(input string tag);
        outs_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            check(tag, obs, e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async", obs, '0);
        @(posedge clk);
        #1;
        check("rst_hold", obs, '0);
        rst = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input int df, input int dm, input logic beq);
        bit tr;
        instr = ins;
        br_eq = beq;
        gen(ins, df, dm, beq, tr);
        play(tag);
        if (tr) do_reset();
    endtask

    function automatic int rdelay();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO + 1)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] tab [8];
        logic [31:0] ins;
        tab = '{O_R, O_IMM, O_LD, O_ST, O_LUI, O_BR, O_JAL, 7'h00};
        @(posedge clk);
        #1;
        check("reset", obs, '0);
        rst = 1'b0;
        run("addi", 32'h00500093, 0, 0, 1'b0);
        run("sub", enc(O_R, 3'd0, 7'h20), 1, 0, 1'b0);
        run("srai", enc(O_IMM, 3'd5, 7'h20), 0, 0, 1'b0);
        run("slli", enc(O_IMM, 3'd1, 7'h00), 2, 0, 1'b0);
        run("lw", enc(O_LD, 3'd2, 7'h00), 0, 3, 1'b0);
        run("sw", enc(O_ST, 3'd2, 7'h00), 0, 2, 1'b0);
        run("lui", enc(O_LUI, 3'd7, 7'h55), 0, 0, 1'b0);
        run("ready_edge", enc(O_LD, 3'd2, 7'h00), TO - 1, TO - 1, 1'b0);
        run("beq_t", enc(O_BR, 3'd0, 7'h00), 0, 0, 1'b1);
        run("beq_n", enc(O_BR, 3'd0, 7'h00), 0, 0, 1'b0);
        run("bne_n", enc(O_BR, 3'd1, 7'h00), 0, 0, 1'b1);
        run("jal", enc(O_JAL, 3'd3, 7'h12), 1, 0, 1'b0);
        run("illegal", 32'h0000007F, 0, 0, 1'b0);
        run("to_fetch", 32'h00500093, TO, 0, 1'b0);
        run("to_mem", enc(O_ST, 3'd2, 7'h00), 0, TO + 2, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        check("wait_req", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_drop", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 80; n++) begin
            ins = $urandom;
            ins[6:0] = tab[$urandom_range(0, 7)];
            if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
            run("rand", ins, rdelay(), rdelay(), rb());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
